// File: rtl/moore_det_pkg.sv
// Shared helpers for the Moore pattern detector: state width and the
// elaboration-time KMP next-state function. Counter option: MOORE_DET_CNT_EN.
package moore_det_pkg;

  localparam int MAX_LEN = 16;

  function automatic int state_w(int len);
    return $clog2(len + 1);
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, b).
  function automatic int next_prefix(
    logic [MAX_LEN-1:0] pattern,
    int                 len,
    int                 k,
    logic               b,
    bit                 overlap
  );
    logic [MAX_LEN:0] seq;
    int               res;
    int               n;
    bit               ok;
    res = 0;
    seq = '0;
    if (k >= len && !overlap) begin
      res = (b == pattern[len-1]) ? 1 : 0;
    end else begin
      for (int i = 0; i < k; i++) seq[i] = pattern[len-1-i];
      seq[k] = b;
      n = (k + 1 > len) ? len : k + 1;
      for (int j = 1; j <= n; j++) begin
        ok = 1'b1;
        for (int m = 0; m < j; m++)
          if (seq[k+1-j+m] != pattern[len-1-m]) ok = 1'b0;
        if (ok) res = j;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/moore_det_if.sv
// Serial-input bundle of the Moore detector.
// match_cnt exists only when MOORE_DET_CNT_EN is defined.
interface moore_det_if #(
  parameter int SW = 3
`ifdef MOORE_DET_CNT_EN
  , parameter int CNT_W = 8
`endif
);
  logic          clr;
  logic          in_valid;
  logic          in;
  logic          out;
  logic [SW-1:0] state;
`ifdef MOORE_DET_CNT_EN
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output clr, in_valid, in,
    input  out, state, match_cnt
  );
  modport slave (
    input  clr, in_valid, in,
    output out, state, match_cnt
  );
`else
  modport master (
    output clr, in_valid, in,
    input  out, state
  );
  modport slave (
    input  clr, in_valid, in,
    output out, state
  );
`endif
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) q_d = '0;
    else if (inc && (q_q != '1)) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;

  assign q = q_q;
endmodule

// File: rtl/moore_seq_det.sv
// Parametrised Moore serial pattern detector with KMP transition table.
// Optional saturating match counter enabled by MOORE_DET_CNT_EN.
module moore_seq_det
  import moore_det_pkg::*;
#(
  parameter int               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input logic        clk,
  input logic        rst_n,
  moore_det_if.slave bus
);
  localparam int SW = state_w(PAT_LEN);
  localparam int NS = 1 << SW;

  logic [SW-1:0] tab0 [NS];
  logic [SW-1:0] tab1 [NS];
  logic [SW-1:0] state_q, state_d;

  if (PAT_LEN < 2 || PAT_LEN > MAX_LEN || CNT_W < 1) begin : g_bad_cfg
    $error("moore_seq_det: parameter out of range");
  end

  // Unreachable codes above PAT_LEN fall back to the empty state.
  for (genvar k = 0; k < NS; k++) begin : g_tab
    if (k <= PAT_LEN) begin : g_live
      localparam int N0 = next_prefix(MAX_LEN'(PATTERN), PAT_LEN, k,
                                      1'b0, OVERLAP != 0);
      localparam int N1 = next_prefix(MAX_LEN'(PATTERN), PAT_LEN, k,
                                      1'b1, OVERLAP != 0);
      assign tab0[k] = SW'(N0);
      assign tab1[k] = SW'(N1);
    end else begin : g_dead
      assign tab0[k] = '0;
      assign tab1[k] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clr)           state_d = '0;
    else if (bus.in_valid) state_d = bus.in ? tab1[state_q] : tab0[state_q];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= '0;
    else        state_q <= state_d;

  assign bus.state = state_q;
  assign bus.out   = (state_q == SW'(PAT_LEN));

`ifdef MOORE_DET_CNT_EN
  logic hit;
  assign hit = bus.in_valid && !bus.clr && (state_d == SW'(PAT_LEN));

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr),
    .inc   (hit),
    .q     (bus.match_cnt)
  );
`endif
endmodule

// File: tb/tb_moore_seq_det.sv
// Directed bench: overlap / non-overlap / saturating instances of the
// detector with a scoreboard of expected state, out and match_cnt.
module tb_moore_seq_det;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v_ab = 1'b0, i_ab = 1'b0, c_ab = 1'b0;
  logic v_c = 1'b0, i_c = 1'b0, c_c = 1'b0;

  always #5 clk = ~clk;

`ifdef MOORE_DET_CNT_EN
  moore_det_if #(.SW(3), .CNT_W(8)) bus_a ();
  moore_det_if #(.SW(3), .CNT_W(8)) bus_b ();
  moore_det_if #(.SW(2), .CNT_W(2)) bus_c ();
`else
  moore_det_if #(.SW(3)) bus_a ();
  moore_det_if #(.SW(3)) bus_b ();
  moore_det_if #(.SW(2)) bus_c ();
`endif

  assign bus_a.clr = c_ab;
  assign bus_a.in_valid = v_ab;
  assign bus_a.in = i_ab;
  assign bus_b.clr = c_ab;
  assign bus_b.in_valid = v_ab;
  assign bus_b.in = i_ab;
  assign bus_c.clr = c_c;
  assign bus_c.in_valid = v_c;
  assign bus_c.in = i_c;

  moore_seq_det #(
    .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

  moore_seq_det #(
    .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  moore_seq_det #(
    .PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(2)
  ) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  int passed = 0;
  int total = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty got %0d want an entry", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) passed++;
      else $error("FAIL %s got %0d want %0d", t, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_ab(input logic v, input logic b, input logic c,
                         input int sa, input int sb);
    v_ab = v; i_ab = b; c_ab = c;
    push("a_state", 32'(sa));
    push("a_out", 32'(sa == 4));
    push("b_state", 32'(sb));
    push("b_out", 32'(sb == 4));
    tick();
    pop_chk(32'(bus_a.state));
    pop_chk(32'(bus_a.out));
    pop_chk(32'(bus_b.state));
    pop_chk(32'(bus_b.out));
  endtask

  task automatic chk_all_zero(input string t);
    push({t, "_a_state"}, 0); push({t, "_a_out"}, 0);
    push({t, "_b_state"}, 0); push({t, "_b_out"}, 0);
    push({t, "_c_state"}, 0); push({t, "_c_out"}, 0);
    pop_chk(32'(bus_a.state)); pop_chk(32'(bus_a.out));
    pop_chk(32'(bus_b.state)); pop_chk(32'(bus_b.out));
    pop_chk(32'(bus_c.state)); pop_chk(32'(bus_c.out));
`ifdef MOORE_DET_CNT_EN
    push({t, "_a_cnt"}, 0); push({t, "_b_cnt"}, 0);
    push({t, "_c_cnt"}, 0);
    pop_chk(32'(bus_a.match_cnt)); pop_chk(32'(bus_b.match_cnt));
    pop_chk(32'(bus_c.match_cnt));
`endif
  endtask

  // Called just after an edge: pulses reset between edges.
  task automatic async_rst(input string t);
    #2 rst_n = 1'b0;
    #1 chk_all_zero(t);
    #1 rst_n = 1'b1;
  endtask

  int ov_a[7] = '{1, 2, 3, 4, 2, 3, 4};
  int ov_b[7] = '{1, 2, 3, 4, 0, 1, 1};
  logic ov_bits[7] = '{1, 0, 1, 1, 0, 1, 1};
  int sat_s[8] = '{1, 2, 3, 3, 3, 3, 3, 3};
  int sat_n[8] = '{0, 0, 1, 2, 3, 3, 3, 3};

  initial begin
    tick();
    chk_all_zero("reset");
    #4 rst_n = 1'b1;

    // partial match lost on asynchronous reset
    step_ab(1, 1, 0, 1, 1);
    step_ab(1, 0, 0, 2, 2);
    step_ab(1, 1, 0, 3, 3);
    async_rst("mid_rst");
    step_ab(1, 1, 0, 1, 1);

    // overlap vs non-overlap on the same stream
    async_rst("pre_ov");
    for (int i = 0; i < 7; i++)
      step_ab(1, ov_bits[i], 0, ov_a[i], ov_b[i]);
`ifdef MOORE_DET_CNT_EN
    push("ov_a_cnt", 2); pop_chk(32'(bus_a.match_cnt));
    push("ov_b_cnt", 1); pop_chk(32'(bus_b.match_cnt));
`endif

    // valid gating with random data in the gaps, then clear
    async_rst("pre_gate");
    step_ab(1, 1, 0, 1, 1);
    step_ab(0, 1'($urandom_range(0, 1)), 0, 1, 1);
    step_ab(0, 1'($urandom_range(0, 1)), 0, 1, 1);
    step_ab(1, 0, 0, 2, 2);
    step_ab(0, 1'($urandom_range(0, 1)), 0, 2, 2);
    step_ab(1, 1, 0, 3, 3);
    step_ab(1, 1, 0, 4, 4);
    step_ab(0, 1'($urandom_range(0, 1)), 0, 4, 4);
    step_ab(0, 1'($urandom_range(0, 1)), 0, 4, 4);
`ifdef MOORE_DET_CNT_EN
    push("gate_a_cnt", 1); pop_chk(32'(bus_a.match_cnt));
`endif
    step_ab(1, 1, 1, 0, 0);
`ifdef MOORE_DET_CNT_EN
    push("clr_a_cnt", 0); pop_chk(32'(bus_a.match_cnt));
    push("clr_b_cnt", 0); pop_chk(32'(bus_b.match_cnt));
`endif
    step_ab(1, 1, 0, 1, 1);
    v_ab = 1'b0;

    // self-overlapping 111 with a 2-bit saturating counter
    async_rst("pre_sat");
    for (int i = 0; i < 8; i++) begin
      v_c = 1'b1; i_c = 1'b1; c_c = 1'b0;
      push("sat_state", 32'(sat_s[i]));
      push("sat_out", (i >= 2) ? 32'd1 : 32'd0);
`ifdef MOORE_DET_CNT_EN
      push("sat_cnt", 32'(sat_n[i]));
`endif
      tick();
      pop_chk(32'(bus_c.state));
      pop_chk(32'(bus_c.out));
`ifdef MOORE_DET_CNT_EN
      pop_chk(32'(bus_c.match_cnt));
`endif
    end
    v_c = 1'b0;
    tick();

    if (exp_q.size() != 0) begin
      total++;
      $error("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
